// File: rtl/keypad_pkg.sv
// Shared types, key map and small bit-test helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    HOLD,
    PRESSED,
    RELEASE
  } scan_state_t;

  // Nibble (row*4 + col) holds the hex code: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic col_single_active(input logic [3:0] col);
    return is_onehot4(~col);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic [3:0] keymap_code(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad columns.
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] col_sync
);

  logic [3:0] meta_reg;

  // Reset to all-high so an idle keypad is seen immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      meta_reg <= col_n;
      col_sync <= meta_reg;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row scanner / keypress sequencer: freezes on a single active column, turns each
// debouncer validation into one key_code pulse and waits for a clean release.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 3,
  parameter int RELEASE_CYCLES = 30000,
  parameter int CNT_W          = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  input  logic       key_valid,
  input  logic [3:0] key_row,
  input  logic [3:0] key_col,
  output logic [3:0] row_n,
  output logic       key_detected,
  output logic [3:0] row_idx,
  output logic [3:0] col_sync,
  output logic       new_key,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  scan_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             key_valid_q;

  logic       col_idle;
  logic       col_single;
  logic       valid_rise;
  logic       valid_fall;
  logic       key_ok;
  logic [3:0] press_code;

  keypad_col_sync u_col_sync (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .col_sync (col_sync)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_row_drive
    assign row_n[gi] = ~row_idx[gi];
  end

  assign col_idle   = (col_sync == 4'b1111);
  assign col_single = col_single_active(col_sync);
  assign valid_rise = key_valid & ~key_valid_q;
  assign valid_fall = ~key_valid & key_valid_q;
  assign key_ok     = is_onehot4(key_row) & is_onehot4(key_col);
  assign press_code = keymap_code(onehot_index(key_row), onehot_index(key_col));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SCAN;
      cnt_reg      <= '0;
      key_valid_q  <= 1'b0;
      row_idx      <= 4'b0001;
      key_detected <= 1'b0;
      new_key      <= 1'b0;
      key_code     <= 4'h0;
      digit_new    <= 4'h0;
      digit_old    <= 4'h0;
    end else begin
      key_valid_q <= key_valid;
      new_key     <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (cnt_reg == SETTLE_LAST) begin
            if (col_single) begin
              state_reg    <= HOLD;
              key_detected <= 1'b1;
            end else begin
              row_idx <= {row_idx[2:0], row_idx[3]};
              cnt_reg <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        HOLD: begin
          // A validation wins over a simultaneous release so the press is not lost.
          if (valid_rise && key_ok) begin
            new_key      <= 1'b1;
            key_code     <= press_code;
            digit_old    <= digit_new;
            digit_new    <= press_code;
            key_detected <= ~col_idle;
            state_reg    <= PRESSED;
          end else if (col_idle) begin
            key_detected <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= SCAN;
          end
        end
        PRESSED: begin
          if (valid_fall) begin
            key_detected <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= RELEASE;
          end else begin
            key_detected <= ~col_idle;
          end
        end
        RELEASE: begin
          if (!col_idle) begin
            cnt_reg <= '0;
          end else if (cnt_reg == RELEASE_LAST) begin
            row_idx   <= {row_idx[2:0], row_idx[3]};
            cnt_reg   <= '0;
            state_reg <= SCAN;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

endmodule
